// File: rtl/vga_fb_pkg.sv
// Shared constants and arbiter state encoding for the VGA frame-buffer arbiter.
package vga_fb_pkg;

    localparam int unsigned DATA_W     = 12;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned FB_WORDS   = 19200;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned LOW_WATER  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFetchWait,
        StCpuWait
    } arb_state_e;

endpackage

// File: rtl/fb_prefetch_fifo.sv
// Pixel prefetch FIFO: synchronous push/pop with flush; head is visible combinationally.
module fb_prefetch_fifo #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_level;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (PTR_W+1)'(DEPTH));
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    // Flush dominates both strobes so a discarded word can never land after the clear.
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: prefetches scanout pixels and interleaves Wishbone CPU accesses.
module vga_fb_arbiter #(
    parameter int unsigned DATA_W     = vga_fb_pkg::DATA_W,
    parameter int unsigned ADDR_W     = vga_fb_pkg::ADDR_W,
    parameter int unsigned FB_WORDS   = vga_fb_pkg::FB_WORDS,
    parameter int unsigned FIFO_DEPTH = vga_fb_pkg::FIFO_DEPTH,
    parameter int unsigned LOW_WATER  = vga_fb_pkg::LOW_WATER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start_i,
    input  logic              pix_rd_i,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              pix_valid_o,
    output logic              underflow_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_adr_i,
    input  logic [DATA_W-1:0] cpu_dat_i,
    output logic [DATA_W-1:0] cpu_dat_o,
    output logic              cpu_ack_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_dat_o,
    input  logic [DATA_W-1:0] ram_dat_i
);
    import vga_fb_pkg::*;

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic [ADDR_W-1:0] r_fptr;
    logic              r_cpu_rd;
    logic              r_cpu_oor;
    logic [DATA_W-1:0] r_cpu_dat;
    logic              r_underflow;

    logic [LVL_W-1:0]  w_level;
    logic              w_empty;
    logic              w_full;
    logic [DATA_W-1:0] w_head;
    logic              w_fetch_ok;
    logic              w_fetch_go;
    logic              w_cpu_go;
    logic              w_cpu_in_range;
    logic              w_push;
    logic              w_pop;
    logic              w_ack;
    logic [DATA_W-1:0] w_cpu_rdata;

    // Only one RAM access is ever outstanding, so in IDLE nothing is in flight and the
    // level alone bounds the FIFO occupancy. A fetch is never started on a flush cycle.
    assign w_fetch_ok     = (32'(w_level) < FIFO_DEPTH) && (32'(r_fptr) < FB_WORDS)
                            && !frame_start_i;
    assign w_cpu_in_range = (32'(cpu_adr_i) < FB_WORDS);

    always_comb begin
        w_state_next = r_state;
        ram_adr_o    = '0;
        ram_we_o     = 1'b0;
        ram_dat_o    = '0;
        w_fetch_go   = 1'b0;
        w_cpu_go     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!rst) begin
                    if (w_fetch_ok && ((32'(w_level) < LOW_WATER) || !cpu_req_i)) begin
                        ram_adr_o    = r_fptr;
                        w_fetch_go   = 1'b1;
                        w_state_next = StFetchWait;
                    end else if (cpu_req_i) begin
                        w_cpu_go     = 1'b1;
                        w_state_next = StCpuWait;
                        if (w_cpu_in_range) begin
                            ram_adr_o = cpu_adr_i;
                            ram_we_o  = cpu_we_i;
                            ram_dat_o = cpu_dat_i;
                        end
                    end
                end
            end
            StFetchWait: w_state_next = StIdle;
            StCpuWait:   w_state_next = StIdle;
            default:     w_state_next = StIdle;
        endcase
    end

    assign w_push      = (r_state == StFetchWait) && !frame_start_i;
    assign w_pop       = pix_rd_i && !w_empty && !frame_start_i;
    assign pix_valid_o = w_pop;
    assign pix_data_o  = w_pop ? w_head : '0;
    assign underflow_o = r_underflow;

    assign w_ack       = (r_state == StCpuWait);
    assign w_cpu_rdata = r_cpu_oor ? '0 : ram_dat_i;
    assign cpu_ack_o   = w_ack;
    assign cpu_dat_o   = (w_ack && r_cpu_rd) ? w_cpu_rdata : r_cpu_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_fptr      <= '0;
            r_cpu_rd    <= 1'b0;
            r_cpu_oor   <= 1'b0;
            r_cpu_dat   <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (frame_start_i) begin
                r_fptr <= '0;
            end else if (w_fetch_go) begin
                r_fptr <= r_fptr + 1'b1;
            end
            if (w_cpu_go) begin
                r_cpu_rd  <= !cpu_we_i;
                r_cpu_oor <= !w_cpu_in_range;
            end
            if (w_ack && r_cpu_rd) begin
                r_cpu_dat <= w_cpu_rdata;
            end
            if (frame_start_i) begin
                r_underflow <= 1'b0;
            end else if (pix_rd_i && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fb_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (frame_start_i),
        .i_push  (w_push),
        .i_data  (ram_dat_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (w_level),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized self-checking bench for vga_fb_arbiter with a behavioural RAM and frame model.
module tb_vga_fb_arbiter;
    localparam int unsigned DW    = 12;
    localparam int unsigned AW    = 15;
    localparam int unsigned FBW   = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 4;
    localparam int unsigned IW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start_i;
    logic          pix_rd_i;
    logic [DW-1:0] pix_data_o;
    logic          pix_valid_o;
    logic          underflow_o;
    logic          cpu_req_i;
    logic          cpu_we_i;
    logic [AW-1:0] cpu_adr_i;
    logic [DW-1:0] cpu_dat_i;
    logic [DW-1:0] cpu_dat_o;
    logic          cpu_ack_o;
    logic [AW-1:0] ram_adr_o;
    logic          ram_we_o;
    logic [DW-1:0] ram_dat_o;
    logic [DW-1:0] ram_dat_i;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FB_WORDS   (FBW),
        .FIFO_DEPTH (DEPTH),
        .LOW_WATER  (LW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start_i),
        .pix_rd_i      (pix_rd_i),
        .pix_data_o    (pix_data_o),
        .pix_valid_o   (pix_valid_o),
        .underflow_o   (underflow_o),
        .cpu_req_i     (cpu_req_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_adr_i     (cpu_adr_i),
        .cpu_dat_i     (cpu_dat_i),
        .cpu_dat_o     (cpu_dat_o),
        .cpu_ack_o     (cpu_ack_o),
        .ram_adr_o     (ram_adr_o),
        .ram_we_o      (ram_we_o),
        .ram_dat_o     (ram_dat_o),
        .ram_dat_i     (ram_dat_i)
    );

    function automatic logic [DW-1:0] pattern(input int i);
        return {4'(i), 8'(i * 37 + 5)};
    endfunction

    // Behavioural single-port RAM with one cycle of read latency.
    logic [DW-1:0] ram [FBW];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FBW; i++) ram[i] <= pattern(i);
        end else if (ram_we_o && (32'(ram_adr_o) < FBW)) begin
            ram[ram_adr_o[IW-1:0]] <= ram_dat_o;
        end
        ram_dat_i <= (32'(ram_adr_o) < FBW) ? ram[ram_adr_o[IW-1:0]] : '0;
    end

    // Reference frame contents; prev_mem holds the value before the single random write per
    // address, since a fetch may legitimately see either side of that write.
    logic [DW-1:0] exp_mem  [FBW];
    logic [DW-1:0] prev_mem [FBW];
    logic          wr_done  [FBW];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop(output logic v, output logic [DW-1:0] d);
        pix_rd_i = 1'b1;
        @(negedge clk);
        v = pix_valid_o;
        d = pix_data_o;
        @(posedge clk);
        #1;
        pix_rd_i = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              output logic [DW-1:0] rdat, output int cyc, output logic saw_we,
                              output logic [AW-1:0] we_adr, output logic [DW-1:0] we_dat);
        logic acked;
        acked = 1'b0;
        cyc = 0;
        saw_we = 1'b0;
        rdat = '0;
        we_adr = '0;
        we_dat = '0;
        cpu_req_i = 1'b1;
        cpu_we_i  = we;
        cpu_adr_i = adr;
        cpu_dat_i = dat;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (ram_we_o) begin
                saw_we = 1'b1;
                we_adr = ram_adr_o;
                we_dat = ram_dat_o;
            end
            if (cpu_ack_o) begin
                rdat  = cpu_dat_o;
                acked = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        check("cpu_ack_seen", acked, 1);
    endtask

    logic          p_v;
    logic [DW-1:0] p_d;
    logic [DW-1:0] p_exp;
    logic          c_we;
    logic [AW-1:0] c_adr;
    logic [DW-1:0] c_dat;
    logic [DW-1:0] c_rd;
    logic [DW-1:0] c_exp;
    int            c_cyc;
    logic          c_saw;
    logic [AW-1:0] c_wadr;
    logic [DW-1:0] c_wdat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        frame_start_i = 1'b0;
        pix_rd_i  = 1'b0;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        cpu_adr_i = '0;
        cpu_dat_i = '0;
        done = 1'b0;
        for (int i = 0; i < FBW; i++) begin
            exp_mem[i] = pattern(i);
            wr_done[i] = 1'b0;
        end

        // Reset: every output low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_data", pix_data_o, 0);
        check("rst_pix_valid", pix_valid_o, 0);
        check("rst_underflow", underflow_o, 0);
        check("rst_cpu_dat", cpu_dat_o, 0);
        check("rst_cpu_ack", cpu_ack_o, 0);
        check("rst_ram_adr", ram_adr_o, 0);
        check("rst_ram_we", ram_we_o, 0);
        check("rst_ram_dat", ram_dat_o, 0);
        rst = 1'b0;

        // Fill to depth, then drain back-to-back: all eight must be present, in order.
        repeat (30) tick();
        for (int k = 0; k < DEPTH; k++) begin
            pop(p_v, p_d);
            check("fill_valid", p_v, 1);
            check("fill_pix", p_d, exp_mem[k]);
        end

        // CPU write then read-back with the FIFO full.
        repeat (30) tick();
        cpu_access(1'b1, AW'(5), 12'hABC, c_rd, c_cyc, c_saw, c_wadr, c_wdat);
        check("wr_strobe", c_saw, 1);
        check("wr_adr", c_wadr, 5);
        check("wr_dat", c_wdat, 12'hABC);
        check("wr_ack_cycles", c_cyc, 2);
        exp_mem[5] = 12'hABC;
        tick();
        cpu_access(1'b0, AW'(5), '0, c_rd, c_cyc, c_saw, c_wadr, c_wdat);
        check("rd_back", c_rd, 12'hABC);
        check("rd_no_we", c_saw, 0);

        // Scanout every 4th cycle while the CPU hammers random accesses.
        for (int i = 0; i < FBW; i++) prev_mem[i] = exp_mem[i];
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    frame_start_i = 1'b1;
                    tick();
                    frame_start_i = 1'b0;
                    repeat (8) tick();
                    for (int k = 0; k < FBW; k++) begin
                        pop(p_v, p_d);
                        p_exp = (p_d == prev_mem[k]) ? prev_mem[k] : exp_mem[k];
                        check("scan_valid", p_v, 1);
                        check("scan_pix", p_d, p_exp);
                        repeat (3) tick();
                    end
                    check("scan_no_underflow", underflow_o, 0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    c_adr = AW'($urandom_range(0, FBW + 2));
                    c_dat = DW'($urandom);
                    c_we  = 1'b0;
                    c_exp = '0;
                    if ((32'(c_adr) < FBW) && ($urandom_range(0, 1) == 1)
                        && !wr_done[c_adr[IW-1:0]]) begin
                        c_we = 1'b1;
                        prev_mem[c_adr[IW-1:0]] = exp_mem[c_adr[IW-1:0]];
                        wr_done[c_adr[IW-1:0]]  = 1'b1;
                    end else if (32'(c_adr) < FBW) begin
                        c_exp = exp_mem[c_adr[IW-1:0]];
                    end
                    cpu_access(c_we, c_adr, c_dat, c_rd, c_cyc, c_saw, c_wadr, c_wdat);
                    check("scan_cpu_wait_le16", (c_cyc <= 16), 1);
                    if (c_we) begin
                        exp_mem[c_adr[IW-1:0]] = c_dat;
                    end else begin
                        check("scan_cpu_rd", c_rd, c_exp);
                    end
                    tick();
                end
            end
        join

        // Saturation at end of frame: 16 valid pops, the 17th underflows.
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        repeat (40) tick();
        for (int k = 0; k < FBW; k++) begin
            pop(p_v, p_d);
            check("sat_valid", p_v, 1);
            check("sat_pix", p_d, exp_mem[k]);
            repeat (3) tick();
        end
        pop(p_v, p_d);
        check("sat_extra_valid", p_v, 0);
        check("sat_extra_data", p_d, 0);
        check("sat_underflow_set", underflow_o, 1);
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        check("sat_underflow_clr", underflow_o, 0);
        repeat (6) tick();
        pop(p_v, p_d);
        check("restart_valid", p_v, 1);
        check("restart_pix0", p_d, exp_mem[0]);

        // Flush landing on the fetch-wait cycle discards the returning word.
        repeat (30) tick();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        tick();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        pop(p_v, p_d);
        check("flush_empty_valid", p_v, 0);
        check("flush_underflow", underflow_o, 1);
        repeat (6) tick();
        pop(p_v, p_d);
        check("flush_refetch_valid", p_v, 1);
        check("flush_refetch_pix0", p_d, exp_mem[0]);

        // Out-of-range CPU read: no strobe, normal 2-cycle access, data 0.
        repeat (30) tick();
        cpu_access(1'b0, AW'(3), '0, c_rd, c_cyc, c_saw, c_wadr, c_wdat);
        check("pre_oor_rd", c_rd, exp_mem[3]);
        tick();
        cpu_access(1'b0, AW'(FBW), '0, c_rd, c_cyc, c_saw, c_wadr, c_wdat);
        check("oor_no_we", c_saw, 0);
        check("oor_ack_cycles", c_cyc, 2);
        check("oor_rd_zero", c_rd, 0);
        tick();
        check("oor_rd_hold", cpu_dat_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
